// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Collects edge events from N asynchronous pulse pins and serializes them onto
//   a single valid/ready event port with round-robin fairness.
//
//   Each channel: SYNC_STAGES-flop synchronizer -> delay flop -> edge detect ->
//   mode filter -> one-deep pending slot. A registered output stage takes one
//   pending event per cycle, searching from the round-robin pointer upward.
//
// Ports
//   clk         system clock (rising edge)
//   rst_n       asynchronous active-low reset
//   i_pulse     raw pulse inputs, asynchronous to clk
//   i_edge_sel  per-channel mode [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
//   i_ovf_clr   write-1-to-clear for o_ovf
//   i_ready     consumer accepts the current event
//   o_valid     event present on output
//   o_id        channel of current event
//   o_fall      0 = rising edge event, 1 = falling edge event
//   o_pending   per-channel pending slot occupied
//   o_ovf       sticky per-channel overflow flag
module edge_event_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned IDW        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   i_pulse,
    input  logic [2*N-1:0] i_edge_sel,
    input  logic [N-1:0]   i_ovf_clr,
    input  logic           i_ready,
    output logic           o_valid,
    output logic [IDW-1:0] o_id,
    output logic           o_fall,
    output logic [N-1:0]   o_pending,
    output logic [N-1:0]   o_ovf
);

    logic [N-1:0]   sync_q [SYNC_STAGES];
    logic [N-1:0]   dly_q;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   type_q, type_d;
    logic [N-1:0]   ovf_q, ovf_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic           fall_q, fall_d;

    logic [N-1:0]   sync_s, rise, fall, ev, ovf_set, gnt_oh, drain;
    logic           out_free, gnt_found;
    logic [IDW-1:0] gnt_id, idx;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign rise     = sync_s & ~dly_q;
    assign fall     = ~sync_s & dly_q;
    assign out_free = ~valid_q | i_ready;

    // Mode filter: a cycle carries at most one of rise/fall per channel.
    always_comb begin
        ev = '0;
        for (int c = 0; c < N; c++) begin
            ev[c] = (rise[c] & i_edge_sel[2*c]) | (fall[c] & i_edge_sel[2*c+1]);
        end
    end

    // Round-robin search starting at ptr_q, wrapping N-1 -> 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IDW'((32'(ptr_q) + i) % N);
            if (!gnt_found && pend_q[idx]) begin
                gnt_found   = 1'b1;
                gnt_id      = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    assign drain = gnt_oh & {N{out_free}};

    // Pending slots: a new edge reloads a slot that is draining this cycle;
    // otherwise an occupied slot keeps its oldest event and flags overflow.
    always_comb begin
        pend_d  = pend_q;
        type_d  = type_q;
        ovf_set = '0;
        for (int c = 0; c < N; c++) begin
            if (ev[c]) begin
                if (pend_q[c] && !drain[c]) begin
                    ovf_set[c] = 1'b1;
                end else begin
                    pend_d[c] = 1'b1;
                    type_d[c] = fall[c];
                end
            end else if (drain[c]) begin
                pend_d[c] = 1'b0;
            end
        end
        ovf_d = (ovf_q & ~i_ovf_clr) | ovf_set;
    end

    // Output register and pointer advance.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        fall_d  = fall_q;
        ptr_d   = ptr_q;
        if (out_free) begin
            valid_d = gnt_found;
            if (gnt_found) begin
                id_d   = gnt_id;
                fall_d = type_q[gnt_id];
                ptr_d  = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            dly_q   <= '0;
            pend_q  <= '0;
            type_q  <= '0;
            ovf_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q[0] <= i_pulse;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            dly_q   <= sync_s;
            pend_q  <= pend_d;
            type_q  <= type_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            fall_q  <= fall_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_id      = id_q;
    assign o_fall    = fall_q;
    assign o_pending = pend_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4, SYNC_STAGES=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_pulse;
    logic [7:0] i_edge_sel;
    logic [3:0] i_ovf_clr;
    logic       i_ready;
    logic       o_valid;
    logic [1:0] o_id;
    logic       o_fall;
    logic [3:0] o_pending;
    logic [3:0] o_ovf;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter #(
        .N          (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pulse   (i_pulse),
        .i_edge_sel(i_edge_sel),
        .i_ovf_clr (i_ovf_clr),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_id      (o_id),
        .o_fall    (o_fall),
        .o_pending (o_pending),
        .o_ovf     (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks valid always; id/fall only when an event is expected.
    task automatic check_out(input string tag, input logic v, input logic [1:0] id,
                             input logic f, input logic [3:0] pend);
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        if (v) begin
            check({tag, ".id"}, 32'(o_id), 32'(id));
            check({tag, ".fall"}, 32'(o_fall), 32'(f));
        end
        check({tag, ".pending"}, 32'(o_pending), 32'(pend));
    endtask

    initial begin
        // ---------------- reset with inputs active ----------------
        rst_n      = 1'b0;
        i_pulse    = 4'b1111;
        i_edge_sel = 8'hFF;
        i_ovf_clr  = 4'b0000;
        i_ready    = 1'b0;
        step(3);
        check("rst.valid", 32'(o_valid), 0);
        check("rst.id", 32'(o_id), 0);
        check("rst.fall", 32'(o_fall), 0);
        check("rst.pending", 32'(o_pending), 0);
        check("rst.ovf", 32'(o_ovf), 0);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        step(3);
        check_out("rel.e3", 1'b0, 2'd0, 1'b0, 4'b1111);
        step(1);
        check_out("rel.e4", 1'b1, 2'd0, 1'b0, 4'b1110);
        step(1);
        check_out("rel.e5", 1'b1, 2'd1, 1'b0, 4'b1100);
        step(1);
        check_out("rel.e6", 1'b1, 2'd2, 1'b0, 4'b1000);
        step(1);
        check_out("rel.e7", 1'b1, 2'd3, 1'b0, 4'b0000);
        step(1);
        check_out("rel.e8", 1'b0, 2'd0, 1'b0, 4'b0000);
        // Drop pulses with rising-only mode: falls must be discarded.
        i_edge_sel = 8'h55;
        i_pulse    = 4'b0000;
        step(5);
        check_out("quiet", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---------------- single channel, both edges (ptr=0) ----------------
        i_edge_sel = 8'h30;
        i_pulse    = 4'b0100;
        step(3);
        check_out("ch2.e3", 1'b0, 2'd0, 1'b0, 4'b0100);
        step(1);
        check_out("ch2.rise", 1'b1, 2'd2, 1'b0, 4'b0000);
        step(1);
        check_out("ch2.idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        i_pulse = 4'b0000;
        step(4);
        check_out("ch2.fall", 1'b1, 2'd2, 1'b1, 4'b0000);
        step(1);
        check_out("ch2.idle2", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---------------- round robin (move ptr to 2 via ch1) ----------------
        i_edge_sel = 8'h04;
        i_pulse    = 4'b0010;
        step(4);
        check_out("rr.setup", 1'b1, 2'd1, 1'b0, 4'b0000);
        i_edge_sel = 8'h00;
        i_pulse    = 4'b1111;
        step(5);
        check_out("rr.off", 1'b0, 2'd0, 1'b0, 4'b0000);
        i_edge_sel = 8'hAA;
        i_ready    = 1'b0;
        i_pulse    = 4'b0000;
        step(3);
        check_out("rr.pend", 1'b0, 2'd0, 1'b0, 4'b1111);
        step(1);
        check_out("rr.g2", 1'b1, 2'd2, 1'b1, 4'b1011);
        step(1);
        check_out("rr.stall2", 1'b1, 2'd2, 1'b1, 4'b1011);
        i_ready = 1'b1;
        step(1);
        check_out("rr.g3", 1'b1, 2'd3, 1'b1, 4'b0011);
        i_ready = 1'b0;
        step(1);
        check_out("rr.stall3", 1'b1, 2'd3, 1'b1, 4'b0011);
        i_ready = 1'b1;
        step(1);
        check_out("rr.g0", 1'b1, 2'd0, 1'b1, 4'b0010);
        step(1);
        check_out("rr.g1", 1'b1, 2'd1, 1'b1, 4'b0000);
        step(1);
        check_out("rr.done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---------------- overflow on ch1 (ptr=2) ----------------
        i_edge_sel = 8'h04;
        i_ready    = 1'b0;
        i_pulse    = 4'b0010;
        step(4);
        check_out("ovf.first", 1'b1, 2'd1, 1'b0, 4'b0000);
        i_pulse = 4'b0000;
        step(2);
        i_pulse = 4'b0010;
        step(3);
        check_out("ovf.second", 1'b1, 2'd1, 1'b0, 4'b0010);
        check("ovf.none", 32'(o_ovf), 0);
        i_pulse = 4'b0000;
        step(2);
        i_pulse = 4'b0010;
        step(3);
        check("ovf.set", 32'(o_ovf), 32'h2);
        check_out("ovf.kept", 1'b1, 2'd1, 1'b0, 4'b0010);
        i_pulse = 4'b0000;
        step(2);
        i_pulse = 4'b0010;
        step(2);
        i_ovf_clr = 4'b0010;
        step(1);
        i_ovf_clr = 4'b0000;
        check("ovf.setwins", 32'(o_ovf), 32'h2);
        i_ovf_clr = 4'b0010;
        step(1);
        i_ovf_clr = 4'b0000;
        check("ovf.clr", 32'(o_ovf), 0);
        i_ready = 1'b1;
        step(1);
        check_out("ovf.drain", 1'b1, 2'd1, 1'b0, 4'b0000);
        step(1);
        check_out("ovf.empty", 1'b0, 2'd0, 1'b0, 4'b0000);
        i_pulse = 4'b0000;
        step(4);
        check_out("ovf.nomore", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---------------- mode filter on ch0 (ptr=2) ----------------
        i_edge_sel = 8'h01;
        i_pulse    = 4'b0001;
        step(2);
        i_pulse = 4'b0000;
        step(1);
        check_out("mode.pend", 1'b0, 2'd0, 1'b0, 4'b0001);
        step(1);
        check_out("mode.rise", 1'b1, 2'd0, 1'b0, 4'b0000);
        step(3);
        check_out("mode.nofall", 1'b0, 2'd0, 1'b0, 4'b0000);
        i_edge_sel = 8'h00;
        i_pulse    = 4'b0001;
        step(4);
        check_out("mode.off_r", 1'b0, 2'd0, 1'b0, 4'b0000);
        i_pulse = 4'b0000;
        step(4);
        check_out("mode.off_f", 1'b0, 2'd0, 1'b0, 4'b0000);

        // ---------------- async reset mid-stall (ptr=1) ----------------
        i_edge_sel = 8'h50;
        i_ready    = 1'b0;
        i_pulse    = 4'b1100;
        step(4);
        check_out("ar.g2", 1'b1, 2'd2, 1'b0, 4'b1000);
        i_pulse = 4'b0100;
        step(2);
        i_pulse = 4'b1100;
        step(3);
        check("ar.ovf", 32'(o_ovf), 32'h8);
        check_out("ar.stall", 1'b1, 2'd2, 1'b0, 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(o_valid), 0);
        check("ar.pending", 32'(o_pending), 0);
        check("ar.ovf0", 32'(o_ovf), 0);
        i_pulse    = 4'b0000;
        i_edge_sel = 8'h00;
        step(1);
        rst_n = 1'b1;
        step(4);
        check_out("ar.after", 1'b0, 2'd0, 1'b0, 4'b0000);
        check("ar.ovf_after", 32'(o_ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event collector and round-robin scheduler. Each of N asynchronous pulse inputs is synchronized and edge-detected (rising, falling or both, per-channel configurable), events are held in a one-deep pending slot per channel, and a round-robin arbiter serializes them onto a single valid/ready event port. It sits between raw pulse pins and the event-consuming logic (interrupt/status unit), replacing ad-hoc per-pin edge detectors.

## Interface
- N, 4, number of channels (2..16); IDW = $clog2(N) derived
- SYNC_STAGES, 2, synchronizer depth (>=2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_pulse  in  N  raw pulse inputs, asynchronous to clk
- i_edge_sel  in  2*N  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both
- i_ovf_clr  in  N  write-1-to-clear for o_ovf, one-cycle pulses
- i_ready  in  1  consumer accepts event when high with o_valid
- o_valid  out  1  event present on output
- o_id  out  IDW  channel of current event
- o_fall  out  1  0 = rising edge event, 1 = falling edge event
- o_pending  out  N  per-channel pending slot occupied
- o_ovf  out  N  sticky per-channel overflow flag

## Operation
- Reset (async assert, sync release by clock): all sync flops, delay flops, pending slots, o_valid, o_id, o_fall, o_ovf = 0; round-robin pointer = 0.
- Per channel: SYNC_STAGES-flop synchronizer, then one delay flop d. rise = s & ~d, fall = ~s & d, s = last sync stage. Input held high through reset release yields one rising event.
- Event qualified by i_edge_sel of the same cycle; mode 00 discards edges. Changing i_edge_sel never flushes pending or output events.
- Pending slot per channel: pend bit + type bit. Qualified edge sets pend, type = fall.
- Edge arrives while pend set and slot not being drained this cycle: new edge dropped, oldest kept, o_ovf[c] set.
- Edge arrives on same cycle slot is drained into output: slot reloaded with new edge, no overflow.
- Output register is free when o_valid = 0 or (o_valid & i_ready). When free and any pend set: grant first pending channel searching from pointer upward, wrapping N-1 -> 0; load o_id/o_fall, set o_valid, clear that pend, pointer = granted+1 (mod N). When free and none pending: o_valid -> 0.
- o_valid/o_id/o_fall stable while o_valid & ~i_ready.
- o_ovf: set has priority over i_ovf_clr in same cycle; otherwise clr bit clears.
- o_pending = pend bits, registered.

## Timing
- Latency: counting the first clk edge that samples a changed i_pulse as edge 1, pend set at edge SYNC_STAGES+1, o_valid high after edge SYNC_STAGES+2 (4 for default), given empty output.
- Back-to-back throughput: one event per cycle while i_ready held high.
- Two edges on one channel need >= SYNC_STAGES+... spacing only in pulse width: input pulse high for >= 1 clk period guaranteed detectable; shorter pulses unspecified.
- Reset mid-operation: all state cleared immediately (async); in-flight events lost, no output glitch beyond o_valid dropping.
- No combinational path from i_ready or i_pulse to any output.

## Test plan
- Reset: rst_n low with i_pulse=4'b1111, edge_sel all 11 -> all outputs 0; after release, 4 rising events emitted in id order 0,1,2,3, o_fall=0.
- Single channel: ch2 mode 11, pulse 0->1 then 1->0 five cycles later, i_ready=1 -> o_valid after edge 4 with o_id=2,o_fall=0; second event o_fall=1.
- Round robin: all channels pend simultaneously, pointer=2 -> grant order 2,3,0,1; i_ready toggled 1/0 -> outputs stable during stall.
- Overflow: ch1 rising, i_ready=0, then second ch1 rising while pend set -> o_ovf[1]=1, later only first event delivered; i_ovf_clr[1] pulse same cycle as new overflow -> o_ovf[1] stays 1; next clr -> 0.
- Mode filter: ch0 mode 01 sees 0->1->0 -> one event o_fall=0; mode 00 -> no event, o_pending[0]=0.
- Async reset mid-stall: o_valid=1, i_ready=0, rst_n pulsed low between clock edges -> o_valid, o_pending, o_ovf 0 immediately.
